// File: rtl/nbit_shift_register.sv
// rtl/nbit_shift_register.sv - universal shift register with bit counter for UART TX/RX framing
// Parallel load or arm starts a WIDTH-bit frame; busy/done track the frame.

module nbit_shift_register #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] PRELOAD   = '0,
  parameter bit               LSB_FIRST = 1'b1,
  parameter int               CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             ld,
  input  logic             arm,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(1);

  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q_shift;

  // Bit order fixes both the shift direction and which end of q is on the wire.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign q_shift = {sin, q[WIDTH-1:1]};
      assign sout    = q[0];
    end else begin : g_msb_first
      assign q_shift = {q[WIDTH-2:0], sin};
      assign sout    = q[WIDTH-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) begin
      q     <= PRELOAD;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (ld) begin
      q     <= d;
      count <= FULL_COUNT;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (arm) begin
      count <= FULL_COUNT;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (shift_en && busy) begin
      q     <= q_shift;
      count <= count - LAST_COUNT;
      if (count == LAST_COUNT) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        done <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nbit_shift_register.sv
// tb/tb_nbit_shift_register.sv - randomized self-checking bench for nbit_shift_register
// Two instances (LSB-first and MSB-first) share stimulus and are checked against a frame model.

module tb_nbit_shift_register;

  localparam logic [7:0] PRE = 8'h3C;

  logic       clk = 1'b0;
  logic       clr, ld, arm, shift_en, sin;
  logic [7:0] d;
  logic [7:0] q_l, q_m;
  logic       sout_l, sout_m, busy_l, busy_m, done_l, done_m;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  logic [7:0] mq_l, mq_m;
  int         rem;
  logic       mdone;

  always #5 clk = ~clk;

  nbit_shift_register #(.WIDTH(8), .PRELOAD(PRE), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .clr(clr), .d(d), .ld(ld), .arm(arm), .shift_en(shift_en), .sin(sin),
    .q(q_l), .sout(sout_l), .busy(busy_l), .done(done_l)
  );

  nbit_shift_register #(.WIDTH(8), .PRELOAD(PRE), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .clr(clr), .d(d), .ld(ld), .arm(arm), .shift_en(shift_en), .sin(sin),
    .q(q_m), .sout(sout_m), .busy(busy_m), .done(done_m)
  );

  task automatic idle_inputs();
    clr = 1'b0; ld = 1'b0; arm = 1'b0; shift_en = 1'b0; sin = 1'b0; d = 8'h00;
  endtask

  // Advance one edge and apply the frame rules to the model; returns 1 ns after the edge.
  task automatic clk_step();
    @(posedge clk);
    if (clr) begin
      mq_l = PRE; mq_m = PRE; rem = 0; mdone = 1'b0;
    end else if (ld) begin
      mq_l = d; mq_m = d; rem = 8; mdone = 1'b0;
    end else if (arm) begin
      rem = 8; mdone = 1'b0;
    end else if (shift_en && rem > 0) begin
      mq_l  = 8'((mq_l >> 1) | (sin ? 8'h80 : 8'h00));
      mq_m  = 8'((mq_m << 1) | (sin ? 8'h01 : 8'h00));
      rem   = rem - 1;
      mdone = (rem == 0);
    end else begin
      mdone = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    clr = 1'b1; ld = 1'b1; d = 8'hFF; shift_en = 1'b1; sin = 1'b1;
    clk_step();
    clk_step();
    idle_inputs();
    n_total++;
    if ({q_l, q_m} !== {PRE, PRE}) $display("FAIL reset_q: got %h/%h want %h", q_l, q_m, PRE);
    else n_pass++;
    n_total++;
    if ({busy_l, busy_m, done_l, done_m} !== 4'b0000)
      $display("FAIL reset_status: got busy %b%b done %b%b want 0", busy_l, busy_m, done_l, done_m);
    else n_pass++;
    n_total++;
    if ({sout_l, sout_m} !== 2'b00) $display("FAIL reset_sout: got %b%b want 00", sout_l, sout_m);
    else n_pass++;
  endtask

  // Load A5 and shift out 8 bits, optionally with random idle gaps between shifts.
  task automatic run_tx(input string name, input bit gaps);
    logic [0:7] seq;
    int         bad;
    seq = 8'b10100101;
    bad = 0;
    idle_inputs();
    ld = 1'b1; d = 8'hA5;
    clk_step();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) clk_step();
      end
      if (sout_l !== seq[i] || sout_m !== seq[i] || busy_l !== 1'b1 || done_l !== 1'b0) begin
        $display("FAIL %s_bit%0d: got sout %b/%b busy %b done %b want sout %b busy 1 done 0",
                 name, i, sout_l, sout_m, busy_l, done_l, seq[i]);
        bad++;
      end
      shift_en = 1'b1; sin = 1'b0;
      clk_step();
      idle_inputs();
    end
    n_total++;
    if (bad != 0) $display("FAIL %s_sequence: %0d bad bits want 0", name, bad);
    else n_pass++;
    n_total++;
    if ({done_l, done_m, busy_l, busy_m} !== 4'b1100)
      $display("FAIL %s_done: got done %b%b busy %b%b want done 11 busy 00", name, done_l, done_m, busy_l, busy_m);
    else n_pass++;
    n_total++;
    if ({q_l, q_m} !== 16'h0000) $display("FAIL %s_final_q: got %h/%h want 00/00", name, q_l, q_m);
    else n_pass++;
    clk_step();
    n_total++;
    if ({done_l, done_m} !== 2'b00) $display("FAIL %s_done_width: got %b%b want 00", name, done_l, done_m);
    else n_pass++;
  endtask

  task automatic test_rx();
    logic [0:7] bits;
    bits = 8'b11000011;
    idle_inputs();
    arm = 1'b1;
    clk_step();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      shift_en = 1'b1; sin = bits[i];
      clk_step();
    end
    idle_inputs();
    n_total++;
    if ({q_l, q_m} !== 16'hC3C3) $display("FAIL rx_word: got %h/%h want c3/c3", q_l, q_m);
    else n_pass++;
    n_total++;
    if ({done_l, done_m} !== 2'b11) $display("FAIL rx_done: got %b%b want 11", done_l, done_m);
    else n_pass++;
    repeat (3) clk_step();
    n_total++;
    if ({busy_l, busy_m, done_l, done_m} !== 4'b0000)
      $display("FAIL rx_idle_after: got busy %b%b done %b%b want 0", busy_l, busy_m, done_l, done_m);
    else n_pass++;
  endtask

  task automatic test_overshift();
    logic [7:0] hold_l, hold_m;
    int         extra_done;
    hold_l = q_l; hold_m = q_m;
    extra_done = 0;
    for (int i = 0; i < 3; i++) begin
      shift_en = 1'b1; sin = 1'($urandom);
      clk_step();
      if (done_l || done_m) extra_done++;
    end
    idle_inputs();
    n_total++;
    if ({q_l, q_m} !== {hold_l, hold_m})
      $display("FAIL overshift_q: got %h/%h want %h/%h", q_l, q_m, hold_l, hold_m);
    else n_pass++;
    n_total++;
    if (extra_done != 0) $display("FAIL overshift_done: got %0d pulses want 0", extra_done);
    else n_pass++;
  endtask

  task automatic test_ld_shift();
    logic [7:0] v;
    v = 8'($urandom);
    idle_inputs();
    ld = 1'b1; shift_en = 1'b1; sin = 1'b1; d = v;
    clk_step();
    idle_inputs();
    n_total++;
    if ({q_l, q_m, busy_l} !== {v, v, 1'b1})
      $display("FAIL ld_shift: got q %h/%h busy %b want %h busy 1", q_l, q_m, busy_l, v);
    else n_pass++;
  endtask

  task automatic test_reload_mid();
    int early_done;
    early_done = 0;
    idle_inputs();
    ld = 1'b1; d = 8'h5A;
    clk_step();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      shift_en = 1'b1; sin = 1'($urandom);
      clk_step();
    end
    idle_inputs();
    ld = 1'b1; d = 8'h81;
    clk_step();
    idle_inputs();
    for (int i = 0; i < 7; i++) begin
      shift_en = 1'b1; sin = 1'b1;
      clk_step();
      if (done_l || done_m || !busy_l) early_done++;
    end
    n_total++;
    if (early_done != 0) $display("FAIL reload_early_done: got %0d bad cycles want 0", early_done);
    else n_pass++;
    clk_step();
    idle_inputs();
    n_total++;
    if ({done_l, busy_l, q_l, q_m} !== {1'b1, 1'b0, 8'hFF, 8'hFF})
      $display("FAIL reload_done: got done %b busy %b q %h/%h want 1 0 ff/ff", done_l, busy_l, q_l, q_m);
    else n_pass++;
  endtask

  task automatic test_clr_mid();
    int stray;
    stray = 0;
    idle_inputs();
    ld = 1'b1; d = 8'hE7;
    clk_step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      shift_en = 1'b1; sin = 1'b0;
      clk_step();
    end
    clr = 1'b1;
    clk_step();
    idle_inputs();
    n_total++;
    if ({busy_l, busy_m, done_l, done_m, q_l} !== {4'b0000, PRE})
      $display("FAIL clr_mid: got busy %b done %b q %h want busy 0 done 0 q %h", busy_l, done_l, q_l, PRE);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      shift_en = 1'b1;
      clk_step();
      if (done_l || done_m) stray++;
    end
    idle_inputs();
    n_total++;
    if (stray != 0) $display("FAIL clr_mid_no_done: got %0d pulses want 0", stray);
    else n_pass++;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      clr      = ($urandom_range(0, 99) < 2);
      ld       = ($urandom_range(0, 99) < 5);
      arm      = ($urandom_range(0, 99) < 4);
      shift_en = ($urandom_range(0, 99) < 60);
      sin      = 1'($urandom);
      d        = 8'($urandom);
      clk_step();
      if ({q_l, q_m, sout_l, sout_m, busy_l, busy_m, done_l, done_m} !==
          {mq_l, mq_m, mq_l[0], mq_m[7], rem > 0, rem > 0, mdone, mdone}) begin
        if (bad < 5)
          $display("FAIL random_cycle%0d: got q %h/%h busy %b done %b want q %h/%h busy %b done %b",
                   i, q_l, q_m, busy_l, done_l, mq_l, mq_m, rem > 0, mdone);
        bad++;
      end
    end
    idle_inputs();
    n_total++;
    if (bad != 0) $display("FAIL random_model: %0d mismatching cycles want 0", bad);
    else n_pass++;
  endtask

  initial begin
    idle_inputs();
    mq_l = PRE; mq_m = PRE; rem = 0; mdone = 1'b0;
    test_reset();
    run_tx("tx", 1'b0);
    test_rx();
    test_overshift();
    run_tx("tx_gaps", 1'b1);
    test_ld_shift();
    test_reload_mid();
    test_clr_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nbit_shift_register.md
# nbit_shift_register

Parametrised universal shift register that succeeds the plain N-bit load register in the software-defined UART datapath. It adds serial shift-in and shift-out, a selectable bit order, and an internal bit counter with busy/done status. The same block serves as the TX serialiser, loaded in parallel and shifted out, and as the RX deserialiser, armed and then shifted in. The UART bit-timing FSM drives `shift_en` once per bit period.

## Interface
Parameters:
- `WIDTH`, 8: data width in bits; minimum 2.
- `PRELOAD`, 0: value `q` takes on reset; WIDTH bits.
- `LSB_FIRST`, 1: 1 shifts right (LSB out, `sin` into MSB); 0 shifts left (MSB out, `sin` into LSB).
- `CNT_W`, `$clog2(WIDTH+1)`: derived counter width; not to be overridden.

Ports:
- `clk`, input, 1: clock. All state changes on the rising edge.
- `clr`, input, 1: reset. Synchronous, active-high.
- `d`, input, WIDTH: parallel load data.
- `ld`, input, 1: parallel load of `d`, which also arms the bit counter.
- `arm`, input, 1: arms the bit counter without changing `q` (RX start).
- `shift_en`, input, 1: one-bit shift request; acted on only while `busy`.
- `sin`, input, 1: serial data in.
- `q`, output, WIDTH: register contents.
- `sout`, output, 1: serial data out, combinational from `q`.
- `busy`, output, 1: counter armed and bits remain.
- `done`, output, 1: one-cycle pulse after the final shift.

## Operation
- Priority per edge: `clr` > `ld` > `arm` > `shift_en`.
- `clr`=1:
  - `q` <= PRELOAD, `count` <= 0, `busy` <= 0, `done` <= 0.
  - All other inputs are ignored that cycle.
- `ld`=1: `q` <= `d`, `count` <= WIDTH, `busy` <= 1, `done` <= 0.
- `arm`=1 (no `ld`): `q` unchanged, `count` <= WIDTH, `busy` <= 1, `done` <= 0.
- `shift_en`=1 with `busy`=1 (no `ld` or `arm`):
  - LSB_FIRST=1: `q` <= {`sin`, `q`[WIDTH-1:1]}.
  - LSB_FIRST=0: `q` <= {`q`[WIDTH-2:0], `sin`}.
  - `count` <= `count`-1.
  - If `count` was 1: `busy` <= 0 and `done` <= 1.
- `shift_en`=1 with `busy`=0: ignored. `q` holds, and `count` never underflows or wraps.
- Default: all state holds, and `done` <= 0. `done` is high for exactly one cycle.
- `sout` = `q`[0] when LSB_FIRST=1, `q`[WIDTH-1] when LSB_FIRST=0. It always reflects the bit that the next shift will emit.
- State is implicit from `busy`:
  - IDLE (`busy`=0) goes to ACTIVE on `ld` or `arm`.
  - ACTIVE returns to IDLE on the WIDTH-th accepted shift, or on `clr`.
- `ld` or `arm` while ACTIVE re-arms the counter to WIDTH and abandons the partial frame. No `done` pulse is issued for the abandoned frame.
- `ld` or `arm` in the same cycle `done` is high: `done` drops next cycle and `busy` rises.

## Timing
- Reset values: `q`=PRELOAD, `busy`=0, `done`=0, `sout`=PRELOAD's outgoing bit, internal `count`=0.
- Load latency: `q`, `busy` and `sout` are valid one cycle after the `ld` edge.
- Shift latency: `sout` presents the next bit one cycle after each accepted `shift_en`.
- Frame length: exactly WIDTH accepted shifts.
  - `done` is asserted in the cycle following the edge that performed the WIDTH-th shift.
  - `busy` falls on that same edge.
  - At that point `q` holds the fully received word.
- Non-consecutive `shift_en` is allowed; gaps simply hold state.
- No combinational path from any input to any output except `q`-derived `sout`.

## Test plan
- Reset: hold `clr`=1 for 2 cycles with PRELOAD=8'h3C and `ld`=1, `d`=8'hFF asserted. Required: `q`=8'h3C, `busy`=0, `done`=0, `sout`=0.
- TX, LSB_FIRST=1, WIDTH=8: `ld` with `d`=8'hA5, then 8 consecutive `shift_en` with `sin`=0.
  - `sout` sequence: 1,0,1,0,0,1,0,1.
  - `done` high exactly 1 cycle after the 8th shift; final `q`=8'h00.
- RX, LSB_FIRST=1: `arm`, then 8 shifts with `sin` = 1,1,0,0,0,0,1,1. Required: `q`=8'hC3, then a `done` pulse, and `busy`=0 thereafter.
- MSB-first (LSB_FIRST=0): `ld` 8'hA5, then 8 shifts. Required: `sout` sequence 1,0,1,0,0,1,0,1 (MSB first) and `done` pulse.
- Over-shift and gaps: after `done`, 3 further `shift_en`. Required: `q` unchanged and no second `done`. Separately, insert idle cycles between shifts: result identical to the consecutive case.
- Simultaneous and mid-frame events:
  - `ld`+`shift_en` together: load wins, `q`=`d`.
  - `ld` after 4 of 8 shifts: counter restarts, and 8 more shifts are required before `done`.
  - `clr` mid-frame: `busy`=0 and no `done`.
